// File: rtl/vga_frame_reader.sv
// Prefetches RGB565 frame pixels from burst memory into a FIFO and serves them to the
// VGA driver one cycle after each data_req. The read address restarts on every v_sync fall.
module vga_frame_reader #(
  parameter int H_PIXELS   = 1024,
  parameter int V_LINES    = 768,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 24,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              v_sync,
  input  logic              data_req,
  output logic [15:0]       data,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic              underflow
);

  localparam int TOTAL   = H_PIXELS * V_LINES;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int FETCH_W = $clog2(TOTAL + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL    = FILL_W'(FIFO_DEPTH);
  localparam logic [FILL_W-1:0]  FILL_MAX_REQ = FILL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [FETCH_W-1:0] FETCH_TOTAL  = FETCH_W'(TOTAL);
  localparam logic [FETCH_W-1:0] FETCH_STEP   = FETCH_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]  ADDR_BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  ADDR_STEP    = ADDR_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t              state;
  logic                v_sync_d;
  logic                discard;
  logic [FETCH_W-1:0]  fetched;
  logic [CNT_W-1:0]    beat_cnt;
  logic [15:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FILL_W-1:0]   fill;

  logic fs;
  logic pop;
  logic wen;
  logic space_ok;
  logic last_beat;

  // A frame start behaves like an empty FIFO for the reader and a discard for the writer.
  assign fs        = v_sync_d & ~v_sync;
  assign pop       = data_req & (fill != '0) & ~fs;
  assign wen       = mem_rd_valid & ~discard & ~fs & ((fill != FILL_FULL) | pop);
  assign space_ok  = (fill <= FILL_MAX_REQ);
  assign last_beat = mem_rd_valid & (beat_cnt == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (wen) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      v_sync_d  <= 1'b1;
      data      <= 16'h0000;
      underflow <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
    end else begin
      v_sync_d <= v_sync;
      if (data_req) begin
        data      <= pop ? fifo_mem[rd_ptr] : 16'h0000;
        underflow <= underflow | ~pop;
      end
      if (fs) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
      end else begin
        if (wen) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wen, pop})
          2'b10:   fill <= fill + FILL_W'(1);
          2'b01:   fill <= fill - FILL_W'(1);
          default: fill <= fill;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= ADDR_BASE;
      fetched     <= '0;
      discard     <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fs) begin
            mem_rd_addr <= ADDR_BASE;
            fetched     <= '0;
          end else if ((fetched < FETCH_TOTAL) && space_ok) begin
            state      <= REQ;
            mem_rd_req <= 1'b1;
          end
        end
        REQ: begin
          if (fs) discard <= 1'b1;
          if (mem_rd_ack) begin
            mem_rd_req <= 1'b0;
            state      <= DATA;
            beat_cnt   <= mem_rd_valid ? CNT_W'(1) : '0;
          end
        end
        DATA: begin
          if (last_beat) begin
            state    <= IDLE;
            beat_cnt <= '0;
            // A burst interrupted by a frame start rewinds the fetch pointer instead of advancing it.
            if (discard | fs) begin
              mem_rd_addr <= ADDR_BASE;
              fetched     <= '0;
              discard     <= 1'b0;
            end else begin
              mem_rd_addr <= mem_rd_addr + ADDR_STEP;
              fetched     <= fetched + FETCH_STEP;
            end
          end else begin
            if (mem_rd_valid) beat_cnt <= beat_cnt + CNT_W'(1);
            if (fs) discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: a default-size instance with a modelled burst memory
// and a small-frame instance used to count requests per frame.
module tb_vga_frame_reader;

  logic        sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst;
  logic        v_sync;
  logic        data_req;
  logic [15:0] data;
  logic        mem_rd_req;
  logic [23:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic        underflow;

  logic        b_v_sync;
  logic        b_data_req;
  logic [15:0] b_data;
  logic        b_mem_rd_req;
  logic [23:0] b_mem_rd_addr;
  logic        b_mem_rd_ack;
  logic        b_mem_rd_valid;
  logic [15:0] b_mem_rd_data;
  logic        b_underflow;

  vga_frame_reader u_a (
    .sys_clk(sys_clk), .rst(rst), .v_sync(v_sync), .data_req(data_req), .data(data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .underflow(underflow)
  );

  vga_frame_reader #(.H_PIXELS(8), .V_LINES(4), .BURST_LEN(8), .FIFO_DEPTH(16)) u_b (
    .sys_clk(sys_clk), .rst(rst), .v_sync(b_v_sync), .data_req(b_data_req), .data(b_data),
    .mem_rd_req(b_mem_rd_req), .mem_rd_addr(b_mem_rd_addr), .mem_rd_ack(b_mem_rd_ack),
    .mem_rd_valid(b_mem_rd_valid), .mem_rd_data(b_mem_rd_data), .underflow(b_underflow)
  );

  int n_pass = 0;
  int n_total = 0;

  // stimulus intentions, applied at the next falling edge by step()
  bit rst_drv = 1'b1;
  bit vs_drv = 1'b0;
  bit req_drv = 1'b0;
  bit inject = 1'b0;
  bit b_vs_drv = 1'b1;
  bit vs_d_model = 1'b1;

  int          r_state = 0;
  int          r_wait = 0;
  int          r_beat = 0;
  logic [23:0] r_addr = '0;
  bit          drop = 1'b0;
  bit          rd_pend = 1'b0;

  logic [15:0] model_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [23:0] req_log[$];
  logic [23:0] b_log[$];

  task automatic step();
    bit fs;
    bit popped;
    @(negedge sys_clk);
    if (rd_pend) begin
      obs_q.push_back(data);
      rd_pend = 1'b0;
    end
    if (r_state == 0 && mem_rd_req === 1'b1 && !rst_drv) begin
      req_log.push_back(mem_rd_addr);
      r_addr  = mem_rd_addr;
      r_state = 1;
      r_wait  = 2;
    end
    fs = !rst_drv && vs_d_model && !vs_drv;
    if (fs) begin
      model_q.delete();
      if (r_state != 0) drop = 1'b1;
    end
    popped = 1'b0;
    if (req_drv) begin
      if (!fs && model_q.size() > 0) begin
        exp_q.push_back(model_q.pop_front());
        popped = 1'b1;
      end else begin
        exp_q.push_back(16'h0000);
      end
      rd_pend = 1'b1;
    end
    mem_rd_ack   = 1'b0;
    mem_rd_valid = 1'b0;
    if (r_state == 1) begin
      if (r_wait > 0) r_wait--;
      else begin
        mem_rd_ack = 1'b1;
        r_state    = 2;
        r_beat     = 0;
      end
    end else if (r_state == 2) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = r_addr[15:0] + 16'(r_beat);
      if (!drop && (model_q.size() < 256 || popped)) model_q.push_back(mem_rd_data);
      r_beat++;
      if (r_beat == 64) begin
        r_state = 0;
        drop    = 1'b0;
      end
    end
    if (inject) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 16'hBEEF;
      if (!fs && (model_q.size() < 256 || popped)) model_q.push_back(16'hBEEF);
    end
    rst      = rst_drv;
    v_sync   = vs_drv;
    data_req = req_drv;
    b_v_sync = b_vs_drv;
    vs_d_model = rst_drv ? 1'b1 : vs_drv;
  endtask

  // small instance memory: ack together with the first beat, then 7 more beats
  initial begin
    int b_state;
    int b_beat;
    b_state = 0;
    b_beat = 0;
    b_mem_rd_ack = 1'b0;
    b_mem_rd_valid = 1'b0;
    b_mem_rd_data = 16'h0;
    forever begin
      @(negedge sys_clk);
      b_mem_rd_ack = 1'b0;
      b_mem_rd_valid = 1'b0;
      if (b_state == 0) begin
        if (b_mem_rd_req === 1'b1) begin
          b_log.push_back(b_mem_rd_addr);
          b_mem_rd_ack = 1'b1;
          b_mem_rd_valid = 1'b1;
          b_mem_rd_data = b_mem_rd_addr[15:0];
          b_beat = 1;
          b_state = 1;
        end
      end else begin
        b_mem_rd_valid = 1'b1;
        b_mem_rd_data = 16'(b_beat);
        b_beat++;
        if (b_beat == 8) b_state = 0;
      end
    end
  end

  task automatic test_reset();
    repeat (3) step();
    n_total++; if (data !== 16'h0) $display("FAIL reset_data got=%h exp=0000", data); else n_pass++;
    n_total++; if (mem_rd_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", mem_rd_req); else n_pass++;
    n_total++; if (mem_rd_addr !== 24'h0) $display("FAIL reset_addr got=%h exp=000000", mem_rd_addr); else n_pass++;
    n_total++; if (underflow !== 1'b0) $display("FAIL reset_underflow got=%b exp=0", underflow); else n_pass++;
    n_total++; if (u_a.fill !== 9'd0) $display("FAIL reset_fill got=%0d exp=0", u_a.fill); else n_pass++;
    n_total++; if (b_mem_rd_req !== 1'b0) $display("FAIL reset_b_req got=%b exp=0", b_mem_rd_req); else n_pass++;
  endtask

  task automatic test_prefetch();
    int k;
    rst_drv = 1'b0;
    k = 0;
    while (req_log.size() < 1 && k < 20) begin step(); k++; end
    n_total++;
    if (req_log.size() < 1) $display("FAIL first_req timeout: no request seen");
    else if (req_log[0] !== 24'h0) $display("FAIL first_req_addr got=%h exp=000000", req_log[0]);
    else n_pass++;
    k = 0;
    while (req_log.size() < 2 && k < 200) begin step(); k++; end
    n_total++;
    if (req_log.size() < 2) $display("FAIL second_req timeout: %0d requests seen", req_log.size());
    else if (req_log[1] !== 24'd64) $display("FAIL second_req_addr got=%h exp=000040", req_log[1]);
    else n_pass++;
    n_total++; if (u_a.fill !== 9'd64) $display("FAIL fill_after_burst got=%0d exp=64", u_a.fill); else n_pass++;
    repeat (300) step();
    n_total++;
    if (req_log.size() != 4) $display("FAIL prefetch_req_count got=%0d exp=4", req_log.size());
    else if (req_log[2] !== 24'd128 || req_log[3] !== 24'd192)
      $display("FAIL prefetch_addrs got=%h,%h exp=000080,0000c0", req_log[2], req_log[3]);
    else n_pass++;
    n_total++; if (u_a.fill !== 9'd256) $display("FAIL prefetch_full_fill got=%0d exp=256", u_a.fill); else n_pass++;
    n_total++; if (mem_rd_req !== 1'b0) $display("FAIL prefetch_req_idle got=%b exp=0", mem_rd_req); else n_pass++;
  endtask

  task automatic test_read();
    logic [15:0] o;
    logic [15:0] e;
    req_drv = 1'b1;
    repeat (10) step();
    req_drv = 1'b0;
    step();
    n_total++;
    if (obs_q.size() != 10) $display("FAIL read_count got=%0d exp=10", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (o !== e) $display("FAIL read_data got=%h exp=%h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_total++; if (underflow !== 1'b0) $display("FAIL read_underflow got=%b exp=0", underflow); else n_pass++;
  endtask

  task automatic test_underflow();
    int k;
    logic [15:0] o;
    logic [15:0] e;
    vs_drv = 1'b1;
    step();
    vs_drv = 1'b0;
    req_drv = 1'b1;
    step();
    step();
    req_drv = 1'b0;
    n_total++; if (underflow !== 1'b1) $display("FAIL underflow_set got=%b exp=1", underflow); else n_pass++;
    k = 0;
    while (u_a.fill < 9'd8 && k < 100) begin step(); k++; end
    req_drv = 1'b1;
    repeat (3) step();
    req_drv = 1'b0;
    step();
    n_total++; if (underflow !== 1'b1) $display("FAIL underflow_sticky got=%b exp=1", underflow); else n_pass++;
    n_total++;
    if (obs_q.size() != 5) $display("FAIL underflow_read_count got=%0d exp=5", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (o !== e) $display("FAIL underflow_data got=%h exp=%h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_discard();
    int k;
    int n;
    vs_drv = 1'b1;
    step();
    k = 0;
    while (!(r_state == 2 && r_addr == 24'd128 && r_beat == 20) && k < 1000) begin step(); k++; end
    n_total++; if (k >= 1000) $display("FAIL discard_setup timeout: burst at 000080 not reached"); else n_pass++;
    n = req_log.size();
    vs_drv = 1'b0;
    step();
    k = 0;
    while (r_state != 0 && k < 100) begin step(); k++; end
    step();
    n_total++; if (u_a.fill !== 9'd0) $display("FAIL discard_fill got=%0d exp=0", u_a.fill); else n_pass++;
    n_total++; if (req_log.size() != n) $display("FAIL discard_early_req got=%0d exp=%0d", req_log.size(), n); else n_pass++;
    n_total++; if (mem_rd_addr !== 24'h0) $display("FAIL discard_addr got=%h exp=000000", mem_rd_addr); else n_pass++;
    k = 0;
    while (req_log.size() <= n && k < 20) begin step(); k++; end
    n_total++;
    if (req_log.size() <= n) $display("FAIL discard_next_req timeout: no request after frame start");
    else if (req_log[n] !== 24'h0) $display("FAIL discard_next_req_addr got=%h exp=000000", req_log[n]);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    int k;
    logic [15:0] o;
    logic [15:0] e;
    k = 0;
    while (!(u_a.fill == 9'd256 && r_state == 0 && mem_rd_req == 1'b0) && k < 600) begin step(); k++; end
    n_total++; if (k >= 600) $display("FAIL full_setup timeout: fill=%0d", u_a.fill); else n_pass++;
    req_drv = 1'b1;
    inject = 1'b1;
    step();
    inject = 1'b0;
    req_drv = 1'b0;
    step();
    n_total++; if (u_a.fill !== 9'd256) $display("FAIL full_pop_fill got=%0d exp=256", u_a.fill); else n_pass++;
    req_drv = 1'b1;
    repeat (256) step();
    req_drv = 1'b0;
    step();
    n_total++;
    if (obs_q.size() != 257) $display("FAIL full_pop_count got=%0d exp=257", obs_q.size());
    else if (obs_q[256] !== 16'hBEEF) $display("FAIL full_pop_tail got=%h exp=beef", obs_q[256]);
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (o !== e) $display("FAIL full_pop_data got=%h exp=%h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_small_frame();
    int k;
    n_total++;
    if (b_log.size() != 4) $display("FAIL small_req_count got=%0d exp=4", b_log.size()); else n_pass++;
    for (int i = 0; i < 4 && i < b_log.size(); i++) begin
      n_total++;
      if (b_log[i] !== 24'(8 * i)) $display("FAIL small_req_addr got=%h exp=%h", b_log[i], 24'(8 * i));
      else n_pass++;
    end
    repeat (50) step();
    n_total++;
    if (b_log.size() != 4) $display("FAIL small_no_extra_req got=%0d exp=4", b_log.size()); else n_pass++;
    b_vs_drv = 1'b0;
    k = 0;
    while (b_log.size() < 5 && k < 20) begin step(); k++; end
    n_total++;
    if (b_log.size() < 5) $display("FAIL small_restart timeout: no request after frame start");
    else if (b_log[4] !== 24'h0) $display("FAIL small_restart_addr got=%h exp=000000", b_log[4]);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    v_sync = 1'b0;
    data_req = 1'b0;
    mem_rd_ack = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = 16'h0;
    b_v_sync = 1'b1;
    b_data_req = 1'b1;
    test_reset();
    test_prefetch();
    test_read();
    test_underflow();
    test_discard();
    test_full_pop();
    test_small_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
